// File: rtl/osc_pkg.sv
// Shared types and constants for the oscilloscope-style capture block.
package osc_pkg;

  localparam int SAMPLE_W      = 12;
  localparam int CAPTURE_DEPTH = 512;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRETRIG  = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POSTTRIG = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/capture_ram.sv
// Sample memory: synchronous write, registered read whose output register clears on rst.
module capture_ram
  import osc_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = CAPTURE_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/edge_trigger_capture.sv
// Edge-triggered sample capture with pre-trigger history in a circular RAM.
// Define TRIG_AUTO_EN to add the AUTO_TIMEOUT forced trigger in ARMED.
module edge_trigger_capture
  import osc_pkg::*;
#(
  parameter int DATA_W   = SAMPLE_W,
  parameter int DEPTH    = CAPTURE_DEPTH,
  parameter int PRE_TRIG = 128
`ifdef TRIG_AUTO_EN
  , parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        level,
  input  logic                     slope,
  input  logic                     arm,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic                     auto_trig
);

  localparam int AW   = $clog2(DEPTH);
  localparam int POST = DEPTH - PRE_TRIG - 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     start_q, start_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic              trig_q, trig_d;
  logic              we_s, edge_s, timeout_s, fire_s, busy_s, arm_ok_s;

  assign busy_s   = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) || (state_q == ST_POSTTRIG);
  assign arm_ok_s = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign fire_s   = edge_s || timeout_s;

  // Crossing of the threshold between the previous and the current valid sample.
  always_comb begin
    edge_s = 1'b0;
    case (slope)
      SLOPE_RISE: edge_s = prev_ok_q && (prev_q < level) && (sample_in >= level);
      SLOPE_FALL: edge_s = prev_ok_q && (prev_q > level) && (sample_in <= level);
      default:    edge_s = 1'b0;
    endcase
  end

`ifdef TRIG_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] to_q;
  logic          auto_q;

  assign timeout_s = (state_q == ST_ARMED) && (to_q == TW'(AUTO_TIMEOUT - 1));

  // Valid samples seen in ARMED; an edge on the timeout sample keeps auto_q low.
  always_ff @(posedge clk) begin
    if (rst || arm_ok_s) begin
      to_q   <= '0;
      auto_q <= 1'b0;
    end else if ((state_q == ST_ARMED) && sample_valid) begin
      to_q <= to_q + TW'(1);
      if (timeout_s && !edge_s) begin
        auto_q <= 1'b1;
      end
    end
  end

  assign auto_trig = auto_q;
`else
  assign timeout_s = 1'b0;
  assign auto_trig = 1'b0;
`endif

  // Capture sequencing: every valid sample in a busy state is written and advances wptr.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    trig_d    = 1'b0;
    we_s      = 1'b0;
    if (busy_s && sample_valid) begin
      we_s      = 1'b1;
      wptr_d    = wptr_q + AW'(1);
      prev_d    = sample_in;
      prev_ok_d = 1'b1;
    end else begin
      we_s = 1'b0;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d   = (PRE_TRIG == 0) ? ST_ARMED : ST_PRETRIG;
          cnt_d     = '0;
          prev_d    = '0;
          prev_ok_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_PRETRIG: begin
        if (sample_valid && (cnt_q == AW'(PRE_TRIG - 1))) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else if (sample_valid) begin
          cnt_d = cnt_q + AW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ARMED: begin
        if (sample_valid && fire_s) begin
          state_d = (POST == 0) ? ST_DONE : ST_POSTTRIG;
          start_d = wptr_q - AW'(PRE_TRIG);
          trig_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_POSTTRIG: begin
        if (sample_valid && (cnt_q == AW'(POST - 1))) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (sample_valid) begin
          cnt_d = cnt_q + AW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      trig_q    <= trig_d;
    end
  end

  assign busy      = busy_s;
  assign done      = (state_q == ST_DONE);
  assign triggered = trig_q;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we_s),
    .waddr_i (wptr_q),
    .wdata_i (sample_in),
    .raddr_i (start_q + rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_edge_trigger_capture.sv
// Scoreboard bench for edge_trigger_capture: stimulus pushes expectations, a negedge monitor checks.
module tb_edge_trigger_capture;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 512;
  localparam int PRE    = 128;
  localparam int AW     = 9;
`ifdef TRIG_AUTO_EN
  localparam int ATO    = 100;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] level = '0;
  logic              slope = 1'b0;
  logic              arm = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              busy, triggered, done, auto_trig;

  typedef struct {
    int k;
    bit au;
  } trig_t;

  trig_t exp_trig[$];
  int    exp_done[$];
  int    exp_rd[$];
  int    s[$];
  int    errors = 0;
  int    checks = 0;
  int    vcnt = 0;
  bit    new_cap = 1'b0, rd_req = 1'b0, rd_pend = 1'b0, rst_seen = 1'b0, done_prev = 1'b0;

  always #5 clk = ~clk;

  edge_trigger_capture #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE)
`ifdef TRIG_AUTO_EN
    , .AUTO_TIMEOUT(ATO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .level(level), .slope(slope), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .triggered(triggered), .done(done), .auto_trig(auto_trig)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input-side bookkeeping: valid samples consumed since the last genuine arm.
  always @(posedge clk) begin
    rd_pend  <= rd_req;
    rst_seen <= rst;
    if (new_cap) vcnt <= 0;
    else if (sample_valid) vcnt <= vcnt + 1;
  end

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge clk) begin
    trig_t e;
    int    d;
    if (rst_seen) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_triggered", triggered, 0);
      chk("rst_auto", auto_trig, 0);
      chk("rst_rd_data", rd_data, 0);
    end else begin
      if (triggered) begin
        if (exp_trig.size() == 0) chk("unexpected_trigger", 1, 0);
        else begin
          e = exp_trig.pop_front();
          chk("trigger_index", vcnt - 1, e.k);
          chk("auto_trig", auto_trig, e.au);
        end
      end
      if (done && !done_prev) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("done_sample_count", vcnt, d);
        end
      end
      if (rd_pend) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
    done_prev = done;
  end

  // Reference: trigger is the first sample at index >= PRE that crosses, or the timeout sample.
  function automatic void model(input int lv, input bit sl, output int k, output bit au);
    bit hit;
    k  = -1;
    au = 1'b0;
    for (int i = PRE; i < s.size(); i++) begin
      hit = sl ? (s[i-1] > lv && s[i] <= lv) : (s[i-1] < lv && s[i] >= lv);
      if (hit) begin
        k = i;
        return;
      end
`ifdef TRIG_AUTO_EN
      if (i == PRE + ATO - 1) begin
        k  = i;
        au = 1'b1;
        return;
      end
`endif
    end
  endfunction

  task automatic feed(input int n, input int gap_mode, input int arm_at);
    for (int i = 0; i < n && i < s.size(); i++) begin
      int g;
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
      sample_valid = 1'b0;
      repeat (g) tick();
      sample_valid = 1'b1;
      sample_in    = DATA_W'(s[i]);
      arm          = (i == arm_at);
      tick();
      arm = 1'b0;
    end
    sample_valid = 1'b0;
  endtask

  task automatic run_capture(input int lv, input bit sl, input int gap_mode,
                             input int abort_after, input bit arm_post);
    int k;
    bit au;
    level = DATA_W'(lv);
    slope = sl;
    model(lv, sl, k, au);
    arm = 1'b1; new_cap = 1'b1; sample_valid = 1'b0;
    tick();
    arm = 1'b0; new_cap = 1'b0;
    if (k >= 0) exp_trig.push_back('{k: k, au: au});
    if (abort_after >= 0) begin
      feed(k + abort_after + 1, gap_mode, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      return;
    end
    if (k >= 0) exp_done.push_back(k + DEPTH - PRE);
    feed(s.size(), gap_mode, arm_post ? k + 20 : -1);
    if (k < 0) begin
      chk("no_trigger_busy", busy, 1);
      chk("no_trigger_done", done, 0);
      return;
    end
    for (int c = 0; c < 20000 && !done; c++) tick();
    chk("done_reached", done, 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      rd_req  = 1'b1;
      exp_rd.push_back(s[k - PRE + a]);
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Rising ramp, valid every cycle.
    s.delete();
    for (int i = 0; i < 1024; i++) s.push_back(i);
    run_capture(500, 1'b0, 0, -1, 1'b0);

    // Falling ramp with an early crossing that falls inside the pre-trigger window.
    s.delete();
    for (int i = 0; i < 5; i++) begin s.push_back(310); s.push_back(290); end
    for (int i = 1023; i >= 0; i--) s.push_back(i);
    for (int i = 0; i < 100; i++) s.push_back(0);
    run_capture(300, 1'b1, 0, -1, 1'b0);

    // Same rising ramp, valid every third cycle.
    s.delete();
    for (int i = 0; i < 1024; i++) s.push_back(i);
    run_capture(500, 1'b0, 1, -1, 1'b0);

    // Long quiet run so wptr wraps, random gaps, stray arm in POSTTRIG.
    s.delete();
    for (int i = 0; i < 700; i++) s.push_back(int'($urandom_range(0, 400)));
    for (int i = 0; i < 512; i++) s.push_back(2 * i);
    for (int i = 0; i < 300; i++) s.push_back(int'($urandom_range(0, 4095)));
    run_capture(int'($urandom_range(450, 550)), 1'b0, 2, -1, 1'b1);

    // Reset in POSTTRIG, then a fresh falling capture.
    s.delete();
    for (int i = 0; i < 1024; i++) s.push_back(i);
    run_capture(600, 1'b0, 0, 50, 1'b0);
    s.delete();
    for (int i = 0; i < 1500; i++) s.push_back((4095 - 3 * i) > 0 ? 4095 - 3 * i : 0);
    run_capture(int'($urandom_range(1000, 3000)), 1'b1, 2, -1, 1'b0);

    // Constant input below level: only the timeout can end the capture.
    s.delete();
    for (int i = 0; i < 700; i++) s.push_back(200);
    run_capture(500, 1'b0, 0, -1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();

    chk("trig_queue_empty", exp_trig.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
